// File: rtl/mcp_pkg.sv
// Shared definitions for the MCP23S17 register-bank emulator:
// BANK=0 register map, reset values, IOCON bit positions and the pointer-advance rule.
package mcp_pkg;

   localparam logic [7:0] IODIRA   = 8'h00;
   localparam logic [7:0] IODIRB   = 8'h01;
   localparam logic [7:0] IPOLA    = 8'h02;
   localparam logic [7:0] IPOLB    = 8'h03;
   localparam logic [7:0] GPINTENA = 8'h04;
   localparam logic [7:0] GPINTENB = 8'h05;
   localparam logic [7:0] DEFVALA  = 8'h06;
   localparam logic [7:0] DEFVALB  = 8'h07;
   localparam logic [7:0] INTCONA  = 8'h08;
   localparam logic [7:0] INTCONB  = 8'h09;
   localparam logic [7:0] IOCONA   = 8'h0A;
   localparam logic [7:0] IOCONB   = 8'h0B;
   localparam logic [7:0] GPPUA    = 8'h0C;
   localparam logic [7:0] GPPUB    = 8'h0D;
   localparam logic [7:0] INTFA    = 8'h0E;
   localparam logic [7:0] INTFB    = 8'h0F;
   localparam logic [7:0] INTCAPA  = 8'h10;
   localparam logic [7:0] INTCAPB  = 8'h11;
   localparam logic [7:0] GPIOA    = 8'h12;
   localparam logic [7:0] GPIOB    = 8'h13;
   localparam logic [7:0] OLATA    = 8'h14;
   localparam logic [7:0] OLATB    = 8'h15;
   localparam logic [7:0] REG_LAST = 8'h15;

   localparam logic [7:0] IODIR_RST = 8'hFF;
   localparam logic [7:0] REG_RST   = 8'h00;

   localparam int IOCON_BANK   = 7;
   localparam int IOCON_MIRROR = 6;
   localparam int IOCON_SEQOP  = 5;
   localparam int IOCON_HAEN   = 3;

   // In BANK=0 the A/B pair shares one index (address[4:1]); address[0] selects the port.
   typedef enum logic [3:0] {
      IDX_IODIR   = 4'd0,
      IDX_IPOL    = 4'd1,
      IDX_GPINTEN = 4'd2,
      IDX_DEFVAL  = 4'd3,
      IDX_INTCON  = 4'd4,
      IDX_IOCON   = 4'd5,
      IDX_GPPU    = 4'd6,
      IDX_INTF    = 4'd7,
      IDX_INTCAP  = 4'd8,
      IDX_GPIO    = 4'd9,
      IDX_OLAT    = 4'd10
   } reg_idx_e;

   typedef struct packed {
      logic [7:0] iodir;
      logic [7:0] ipol;
      logic [7:0] gpinten;
      logic [7:0] defval;
      logic [7:0] intcon;
      logic [7:0] gppu;
      logic [7:0] intf;
      logic [7:0] intcap;
      logic [7:0] gpio;
      logic [7:0] olat;
   } port_regs_t;

   function automatic logic [7:0] next_ptr(input logic [7:0] ptr, input logic seqop);
      logic [7:0] nxt;
      if (ptr > REG_LAST) begin
         nxt = 8'h00;
      end else if (seqop) begin
         nxt = ptr;
      end else if (ptr == REG_LAST) begin
         nxt = 8'h00;
      end else begin
         nxt = ptr + 8'h01;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/mcp_port.sv
// One GPIO port of the MCP23S17: configuration registers, pin synchroniser,
// change detection and the INTF/INTCAP interrupt state.
module mcp_port
   import mcp_pkg::*;
#(
   parameter int SYNC_STG = 2
) (
   input  logic       sclk_i,
   input  logic       rst,
   input  logic       i_wr_en,
   input  logic [3:0] i_idx,
   input  logic [7:0] i_wr_data,
   input  logic       i_rd_clr,
   input  logic [7:0] i_pins,
   output port_regs_t o_regs
);

   logic [7:0] r_sync [0:SYNC_STG-1];
   logic [7:0] r_prev;
   logic [7:0] r_iodir, r_ipol, r_gpinten, r_defval, r_intcon, r_gppu, r_olat;
   logic [7:0] r_intf, r_intcap;
   logic [7:0] w_pin, w_mismatch, w_set, w_intf_nxt;

   assign w_pin      = r_sync[SYNC_STG-1];
   assign w_mismatch = (r_intcon & (w_pin ^ r_defval)) | (~r_intcon & (w_pin ^ r_prev));
   assign w_set      = w_mismatch & r_gpinten & r_iodir;
   // A new event in the same cycle as a clearing read keeps its flag set.
   assign w_intf_nxt = w_set | (i_rd_clr ? 8'h00 : r_intf);

   // Pin synchroniser and previous-sample register for change detection.
   always_ff @(posedge sclk_i) begin
      if (rst) begin
         for (int k = 0; k < SYNC_STG; k++) begin
            r_sync[k] <= 8'h00;
         end
         r_prev <= 8'h00;
      end else begin
         r_sync[0] <= i_pins;
         for (int k = 1; k < SYNC_STG; k++) begin
            r_sync[k] <= r_sync[k-1];
         end
         r_prev <= w_pin;
      end
   end

   // Host-writable configuration registers; GPIO writes land in OLAT.
   always_ff @(posedge sclk_i) begin
      if (rst) begin
         r_iodir   <= IODIR_RST;
         r_ipol    <= REG_RST;
         r_gpinten <= REG_RST;
         r_defval  <= REG_RST;
         r_intcon  <= REG_RST;
         r_gppu    <= REG_RST;
         r_olat    <= REG_RST;
      end else if (i_wr_en) begin
         case (reg_idx_e'(i_idx))
            IDX_IODIR:   r_iodir   <= i_wr_data;
            IDX_IPOL:    r_ipol    <= i_wr_data;
            IDX_GPINTEN: r_gpinten <= i_wr_data;
            IDX_DEFVAL:  r_defval  <= i_wr_data;
            IDX_INTCON:  r_intcon  <= i_wr_data;
            IDX_GPPU:    r_gppu    <= i_wr_data;
            IDX_GPIO:    r_olat    <= i_wr_data;
            IDX_OLAT:    r_olat    <= i_wr_data;
            default:     r_olat    <= r_olat;
         endcase
      end
   end

   // Interrupt flags; INTCAP records the pins only for the first event.
   always_ff @(posedge sclk_i) begin
      if (rst) begin
         r_intf   <= REG_RST;
         r_intcap <= REG_RST;
      end else begin
         r_intf <= w_intf_nxt;
         if ((w_set != 8'h00) && (r_intf == 8'h00)) begin
            r_intcap <= w_pin;
         end
      end
   end

   assign o_regs.iodir   = r_iodir;
   assign o_regs.ipol    = r_ipol;
   assign o_regs.gpinten = r_gpinten;
   assign o_regs.defval  = r_defval;
   assign o_regs.intcon  = r_intcon;
   assign o_regs.gppu    = r_gppu;
   assign o_regs.intf    = r_intf;
   assign o_regs.intcap  = r_intcap;
   assign o_regs.gpio    = (r_iodir & (w_pin ^ r_ipol)) | (~r_iodir & r_olat);
   assign o_regs.olat    = r_olat;

endmodule

// File: rtl/mcp_regfile.sv
// MCP23S17 register-bank emulator behind the SPI responder: pointer, device select,
// shared IOCON, address decode, read mux and interrupt outputs.
module mcp_regfile
   import mcp_pkg::*;
#(
   parameter logic [2:0] HW_ADDR  = 3'b000,
   parameter int         SYNC_STG = 2
) (
   input  logic       sclk_i,
   input  logic       rst,
   input  logic       cmd_vld_i,
   input  logic [7:0] opcode_i,
   input  logic [7:0] addr_i,
   input  logic       wr_stb_i,
   input  logic [7:0] wr_data_i,
   input  logic       rd_stb_i,
   output logic [7:0] rd_data_o,
   output logic       rd_vld_o,
   output logic       sel_o,
   input  logic [7:0] gpio_a_i,
   input  logic [7:0] gpio_b_i,
   output logic [7:0] gpio_a_o,
   output logic [7:0] gpio_b_o,
   output logic [7:0] gpio_a_oe_o,
   output logic [7:0] gpio_b_oe_o,
   output logic       int_a_o,
   output logic       int_b_o
);

   logic [7:0] r_ptr, r_iocon, r_rd_data;
   logic       r_sel, r_rd_vld, r_int_a, r_int_b;
   logic       w_acc_wr, w_acc_rd, w_rd_any, w_in_map, w_sel_nxt;
   logic       w_wr_a, w_wr_b, w_clr_a, w_clr_b, w_clr_idx, w_any_a, w_any_b;
   logic [3:0] w_idx;
   logic [7:0] w_rd_val;
   port_regs_t w_regs_a, w_regs_b, w_port;

   // Command wins over write, write over read; dropped strobes have no effect.
   assign w_rd_any  = !cmd_vld_i && !wr_stb_i && rd_stb_i;
   assign w_acc_wr  = !cmd_vld_i && wr_stb_i && r_sel;
   assign w_acc_rd  = w_rd_any && r_sel;
   assign w_in_map  = (r_ptr <= REG_LAST);
   assign w_idx     = r_ptr[4:1];
   assign w_sel_nxt = (opcode_i[7:4] == 4'b0100) &&
                      (!r_iocon[IOCON_HAEN] || (opcode_i[3:1] == HW_ADDR));

   assign w_clr_idx = (w_idx == IDX_GPIO) || (w_idx == IDX_INTCAP);
   assign w_wr_a    = w_acc_wr && w_in_map && !r_ptr[0];
   assign w_wr_b    = w_acc_wr && w_in_map &&  r_ptr[0];
   assign w_clr_a   = w_acc_rd && w_in_map && !r_ptr[0] && w_clr_idx;
   assign w_clr_b   = w_acc_rd && w_in_map &&  r_ptr[0] && w_clr_idx;

   mcp_port #(.SYNC_STG(SYNC_STG)) u_port_a (
      .sclk_i    (sclk_i),
      .rst       (rst),
      .i_wr_en   (w_wr_a),
      .i_idx     (w_idx),
      .i_wr_data (wr_data_i),
      .i_rd_clr  (w_clr_a),
      .i_pins    (gpio_a_i),
      .o_regs    (w_regs_a)
   );

   mcp_port #(.SYNC_STG(SYNC_STG)) u_port_b (
      .sclk_i    (sclk_i),
      .rst       (rst),
      .i_wr_en   (w_wr_b),
      .i_idx     (w_idx),
      .i_wr_data (wr_data_i),
      .i_rd_clr  (w_clr_b),
      .i_pins    (gpio_b_i),
      .o_regs    (w_regs_b)
   );

   // Read mux over the BANK=0 map; anything past OLATB reads as zero.
   always_comb begin
      w_port   = r_ptr[0] ? w_regs_b : w_regs_a;
      w_rd_val = 8'h00;
      if (w_in_map) begin
         case (reg_idx_e'(w_idx))
            IDX_IODIR:   w_rd_val = w_port.iodir;
            IDX_IPOL:    w_rd_val = w_port.ipol;
            IDX_GPINTEN: w_rd_val = w_port.gpinten;
            IDX_DEFVAL:  w_rd_val = w_port.defval;
            IDX_INTCON:  w_rd_val = w_port.intcon;
            IDX_IOCON:   w_rd_val = r_iocon;
            IDX_GPPU:    w_rd_val = w_port.gppu;
            IDX_INTF:    w_rd_val = w_port.intf;
            IDX_INTCAP:  w_rd_val = w_port.intcap;
            IDX_GPIO:    w_rd_val = w_port.gpio;
            IDX_OLAT:    w_rd_val = w_port.olat;
            default:     w_rd_val = 8'h00;
         endcase
      end else begin
         w_rd_val = 8'h00;
      end
   end

   assign w_any_a = |w_regs_a.intf;
   assign w_any_b = |w_regs_b.intf;

   // Transaction state, IOCON, read response and interrupt outputs.
   always_ff @(posedge sclk_i) begin
      if (rst) begin
         r_ptr     <= 8'h00;
         r_sel     <= 1'b0;
         r_iocon   <= REG_RST;
         r_rd_data <= 8'h00;
         r_rd_vld  <= 1'b0;
         r_int_a   <= 1'b0;
         r_int_b   <= 1'b0;
      end else begin
         r_rd_vld <= w_rd_any;
         if (w_acc_rd) begin
            r_rd_data <= w_rd_val;
         end else if (w_rd_any) begin
            r_rd_data <= 8'h00;
         end
         if (cmd_vld_i) begin
            r_ptr <= addr_i;
            r_sel <= w_sel_nxt;
         end else if (w_acc_wr || w_acc_rd) begin
            r_ptr <= next_ptr(r_ptr, r_iocon[IOCON_SEQOP]);
         end
         if (w_acc_wr && w_in_map && (w_idx == IDX_IOCON)) begin
            r_iocon <= wr_data_i;
         end
         r_int_a <= r_iocon[IOCON_MIRROR] ? (w_any_a | w_any_b) : w_any_a;
         r_int_b <= r_iocon[IOCON_MIRROR] ? (w_any_a | w_any_b) : w_any_b;
      end
   end

   assign rd_data_o   = r_rd_data;
   assign rd_vld_o    = r_rd_vld;
   assign sel_o       = r_sel;
   assign gpio_a_o    = w_regs_a.olat;
   assign gpio_b_o    = w_regs_b.olat;
   assign gpio_a_oe_o = ~w_regs_a.iodir;
   assign gpio_b_oe_o = ~w_regs_b.iodir;
   assign int_a_o     = r_int_a;
   assign int_b_o     = r_int_b;

endmodule
